axi_burst_rd_master: RTL

//  Parametrised AXI read-channel master that sits between a user read port and the DDR2 controller AXI slave.

---
 rtl/axi_burst_rd_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axi_burst_rd_master.sv
// AXI read-channel master: splits one user read request into boundary-safe INCR bursts,
// forwards R data with downstream backpressure and reports a sticky response/RLAST error.
module axi_burst_rd_master #(
  parameter int unsigned ADDR_WIDTH     = 27,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned BOUNDARY_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_trig,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rlast,
  input  logic [1:0]            axi_rresp
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam logic [2:0]  ARSIZE = 3'($clog2(BYTES));

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nx;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d, rem_nx;
  logic [8:0]            blen_q, blen_d;
  logic [8:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  beat_fire;

  // Beats in the next burst: limited by what is left, MAX_BURST and room before the boundary.
  function automatic logic [8:0] calc_blen(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [LEN_WIDTH-1:0]  rem);
    logic [31:0] room;
    logic [31:0] b;
    room = (BOUNDARY_BYTES - (32'(a) % BOUNDARY_BYTES)) / BYTES;
    b    = MAX_BURST;
    if (room < b)       b = room;
    if (32'(rem) < b)   b = 32'(rem);
    return 9'(b);
  endfunction

  assign rd_ready      = (state_q == S_IDLE);
  assign rd_done       = (state_q == S_DONE);
  assign rd_err        = err_q;
  assign axi_arvalid   = (state_q == S_AR);
  assign axi_araddr    = addr_q;
  assign axi_arlen     = 8'(blen_q - 9'd1);
  assign axi_arsize    = ARSIZE;
  assign axi_arburst   = 2'b01;
  assign axi_rready    = (state_q == S_R) & rd_data_ready;
  assign rd_data_valid = (state_q == S_R) & axi_rvalid;
  assign rd_data       = axi_rdata;
  assign beat_fire     = axi_rvalid & axi_rready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    err_d   = err_q;
    addr_nx = addr_q + ADDR_WIDTH'(32'(blen_q) * BYTES);
    rem_nx  = rem_q - LEN_WIDTH'(blen_q);
    case (state_q)
      S_IDLE: begin
        if (rd_trig) begin
          err_d = 1'b0;
          if (rd_len != '0) begin
            addr_d  = rd_addr;
            rem_d   = rd_len;
            blen_d  = calc_blen(rd_addr, rd_len);
            state_d = S_AR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_AR: begin
        if (axi_arready) begin
          beat_d  = blen_q;
          state_d = S_R;
        end
      end
      S_R: begin
        if (beat_fire) begin
          beat_d = beat_q - 9'd1;
          if ((axi_rresp != 2'b00) || (axi_rlast != (beat_q == 9'd1))) err_d = 1'b1;
          // Burst end is decided by the beat count alone; an early RLAST only flags an error.
          if (beat_q == 9'd1) begin
            addr_d = addr_nx;
            rem_d  = rem_nx;
            if (rem_nx == '0) begin
              state_d = S_DONE;
            end else begin
              blen_d  = calc_blen(addr_nx, rem_nx);
              state_d = S_AR;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= 9'd1;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule
